// File: rtl/otter_intr_ctrl.sv
// rtl/otter_intr_ctrl.sv - interrupt front-end: IRQ sync, pending latch, fixed priority, INTR/CAUSE FSM
module otter_intr_ctrl #(
    parameter int               N_SRC       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter logic [N_SRC-1:0] LEVEL_MASK  = '0,
    localparam int              CW          = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_SRC-1:0] IRQ_IN,
    input  logic [N_SRC-1:0] IRQ_EN,
    input  logic             MIE,
    input  logic             INT_TAKEN,
    output logic             INTR,
    output logic [CW-1:0]    CAUSE,
    output logic [N_SRC-1:0] PENDING
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    logic [N_SRC-1:0] sync_q [SYNC_STAGES];
    logic [N_SRC-1:0] sync_d [SYNC_STAGES];
    logic [N_SRC-1:0] s_dly_q, s_dly_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    state_e           state_q, state_d;
    logic             intr_q, intr_d;
    logic [CW-1:0]    cause_q, cause_d;

    logic [N_SRC-1:0] s_cur;
    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] retire;
    logic [CW-1:0]    winner;

    assign s_cur = sync_q[SYNC_STAGES-1];
    assign elig  = pend_q & IRQ_EN;

    always_comb begin
        sync_d[0] = IRQ_IN;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        s_dly_d = s_cur;
    end

    // Lowest eligible index wins; scanning downward leaves the smallest set index.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                winner = CW'(i);
            end
        end
    end

    always_comb begin
        retire = '0;
        if (state_q == ST_REQ && INT_TAKEN) begin
            retire[cause_q] = 1'b1;
        end
        retire = retire & ~LEVEL_MASK;
    end

    // Set term is OR'd after the retire clear so a fresh edge survives a same-cycle ack.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            if (LEVEL_MASK[i]) begin
                pend_d[i] = s_cur[i];
            end else begin
                pend_d[i] = (pend_q[i] & ~retire[i]) | (s_cur[i] & ~s_dly_q[i]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        intr_d  = intr_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: begin
                intr_d = 1'b0;
                if (MIE && (|elig)) begin
                    cause_d = winner;
                    intr_d  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (INT_TAKEN) begin
                    intr_d  = 1'b0;
                    state_d = ST_HOLD;
                end else if (!MIE || !IRQ_EN[cause_q]) begin
                    intr_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    intr_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                intr_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                intr_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            s_dly_q <= '0;
            pend_q  <= '0;
            state_q <= ST_IDLE;
            intr_q  <= 1'b0;
            cause_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            s_dly_q <= s_dly_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            intr_q  <= intr_d;
            cause_q <= cause_d;
        end
    end

    assign INTR    = intr_q;
    assign CAUSE   = cause_q;
    assign PENDING = pend_q;

endmodule
